// File: rtl/circuito_exp4_pkg.sv
// ---------------------------------------------------------------------------
// circuito_exp4_pkg
// Shared definitions for the memory-game datapath/control:
//   - estado_t       : FSM state encoding (the codes are also shown on db_estado)
//   - ROM_CONTENTS   : the fixed 16-step one-hot play sequence
//   - LAST_ADDR      : address of the final play in the sequence
//   - rom_read()     : combinational ROM lookup
// ---------------------------------------------------------------------------
package circuito_exp4_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL     = 4'h0,
        ST_PREPARACAO  = 4'h1,
        ST_ESPERA      = 4'h2,
        ST_REGISTRA    = 4'h4,
        ST_COMPARACAO  = 4'h5,
        ST_PROXIMO     = 4'h6,
        ST_FIM_ACERTOU = 4'hA,
        ST_FIM_ERROU   = 4'hE
    } estado_t;

    localparam logic [3:0] LAST_ADDR = 4'd15;

    // Element [15] is written first; addresses 0..15 hold
    // 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
    localparam logic [15:0][3:0] ROM_CONTENTS = {
        4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
        4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1
    };

    function automatic logic [3:0] rom_read(input logic [3:0] addr);
        return ROM_CONTENTS[addr];
    endfunction

endpackage

// File: rtl/circuito_exp4_hexa7seg.sv
// ---------------------------------------------------------------------------
// circuito_exp4_hexa7seg
// 4-bit value to 7-segment image, hex digits 0-F.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
//   hexa   in  4  value to display
//   seg    out 7  segment drive
// ---------------------------------------------------------------------------
module circuito_exp4_hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (hexa)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/circuito_exp4.sv
// ---------------------------------------------------------------------------
// circuito_exp4
// Memory game: the player reproduces a fixed 16-step one-hot sequence held
// in an internal ROM, one play at a time on the switches. A Moore FSM
// handles start, play detection, registration, comparison and advance,
// ending in fim_acertou (all 16 matched) or fim_errou (first mismatch).
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous, active-low
//   iniciar         in   start request (level)
//   chaves[3:0]     in   player switches (one-hot play)
//   acertou         out  in fim_acertou
//   errou           out  in fim_errou
//   pronto          out  in either end state
//   leds[3:0]       out  jogada register
//   db_igual        out  jogada register == current ROM word
//   db_contagem     out  7-seg of address counter
//   db_memoria      out  7-seg of current ROM word
//   db_estado       out  7-seg of FSM state code
//   db_jogadafeita  out  7-seg of jogada register
//   db_clock        out  copy of clock
//   db_iniciar      out  copy of iniciar
//   db_tem_jogada   out  one-cycle play-detect pulse
// ---------------------------------------------------------------------------
import circuito_exp4_pkg::*;

module circuito_exp4 #(
    parameter int unsigned CLK_HZ = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    // CLK_HZ is informational only; reject a meaningless value at elaboration.
    if (CLK_HZ == 0) begin : g_clk_hz_invalid
        $error("circuito_exp4: CLK_HZ must be nonzero");
    end

    estado_t    state_reg;
    estado_t    state_next;
    logic [3:0] contagem_reg;
    logic [3:0] jogada_reg;
    logic       chaves_ativas_reg;

    logic [3:0] rom_word;
    logic       igual;
    logic       chaves_ativas;
    logic       tem_jogada;

    // ---------------- datapath ----------------
    assign rom_word      = rom_read(contagem_reg);
    assign igual         = (jogada_reg == rom_word);
    assign chaves_ativas = |chaves;
    // Rising edge of "any switch on": holding a play gives one pulse,
    // going back to 0000 re-arms the detector.
    assign tem_jogada    = chaves_ativas & ~chaves_ativas_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chaves_ativas_reg <= 1'b0;
        end else begin
            chaves_ativas_reg <= chaves_ativas;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_reg <= 4'd0;
        end else if (state_reg == ST_PREPARACAO) begin
            contagem_reg <= 4'd0;
        end else if (state_reg == ST_PROXIMO) begin
            contagem_reg <= contagem_reg + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada_reg <= 4'd0;
        end else if (state_reg == ST_PREPARACAO) begin
            jogada_reg <= 4'd0;
        end else if (state_reg == ST_REGISTRA) begin
            jogada_reg <= chaves;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_INICIAL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INICIAL:     if (iniciar) state_next = ST_PREPARACAO;
            ST_PREPARACAO:  state_next = ST_ESPERA;
            ST_ESPERA:      if (tem_jogada) state_next = ST_REGISTRA;
            ST_REGISTRA:    state_next = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!igual) begin
                    state_next = ST_FIM_ERROU;
                end else if (contagem_reg == LAST_ADDR) begin
                    state_next = ST_FIM_ACERTOU;
                end else begin
                    state_next = ST_PROXIMO;
                end
            end
            ST_PROXIMO:     state_next = ST_ESPERA;
            ST_FIM_ACERTOU,
            ST_FIM_ERROU:   if (iniciar) state_next = ST_PREPARACAO;
            default:        state_next = ST_INICIAL;
        endcase
    end

    // Moore outputs: decoded from the state only.
    assign acertou = (state_reg == ST_FIM_ACERTOU);
    assign errou   = (state_reg == ST_FIM_ERROU);
    assign pronto  = acertou | errou;

    assign leds          = jogada_reg;
    assign db_igual      = igual;
    assign db_clock      = clock;
    assign db_iniciar    = iniciar;
    assign db_tem_jogada = tem_jogada;

    // ---------------- debug displays ----------------
    // Digit order: 0 counter, 1 ROM word, 2 state, 3 jogada register.
    logic [3:0] digit_value [4];
    logic [6:0] digit_seg   [4];

    assign digit_value[0] = contagem_reg;
    assign digit_value[1] = rom_word;
    assign digit_value[2] = state_reg;
    assign digit_value[3] = jogada_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hex
            circuito_exp4_hexa7seg u_hexa7seg (
                .hexa (digit_value[gi]),
                .seg  (digit_seg[gi])
            );
        end
    endgenerate

    assign db_contagem    = digit_seg[0];
    assign db_memoria     = digit_seg[1];
    assign db_estado      = digit_seg[2];
    assign db_jogadafeita = digit_seg[3];

endmodule

// File: tb/tb_circuito_exp4.sv
module tb_circuito_exp4;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       acertou, errou, pronto;
    logic [3:0] leds;
    logic       db_igual;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;
    logic       db_clock, db_iniciar, db_tem_jogada;

    circuito_exp4 #(.CLK_HZ(1000)) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .chaves         (chaves),
        .acertou        (acertou),
        .errou          (errou),
        .pronto         (pronto),
        .leds           (leds),
        .db_igual       (db_igual),
        .db_contagem    (db_contagem),
        .db_memoria     (db_memoria),
        .db_estado      (db_estado),
        .db_jogadafeita (db_jogadafeita),
        .db_clock       (db_clock),
        .db_iniciar     (db_iniciar),
        .db_tem_jogada  (db_tem_jogada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand-written 7-segment images (active-low, gfedcba) for 0..F.
    logic [6:0] seg_tab [16];
    // Expected play sequence.
    logic [3:0] seq_tab [16];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            $display("ok   %s: %h", name, actual);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Apply one play for 'hold' cycles, then 0000 for 'gap' cycles.
    // Reports how many registra cycles and detect pulses were seen,
    // and db_igual as seen during comparacao.
    task automatic play(input logic [3:0] v, input int hold, input int gap,
                        output int n_reg, output int n_pulse, output logic igual_seen);
        n_reg = 0;
        n_pulse = 0;
        igual_seen = 1'bx;
        chaves = v;
        for (int i = 0; i < hold + gap; i++) begin
            if (i == hold) chaves = 4'b0000;
            @(negedge clock);
            if (db_tem_jogada) n_pulse++;
            if (db_estado == seg_tab[4]) n_reg++;
            if (db_estado == seg_tab[5]) igual_seen = db_igual;
            @(posedge clock);
            #1;
        end
    endtask

    typedef struct {
        logic [3:0] chaves;
        logic [3:0] exp_leds;
        logic [3:0] exp_cnt;
        logic       exp_igual;
        logic [3:0] exp_state;
        logic       exp_errou;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   n_reg, n_pulse;
        logic ig;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        seq_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
        vecs[0] = '{4'b0001, 4'b0001, 4'd1, 1'b1, 4'h2, 1'b0};
        vecs[1] = '{4'b0010, 4'b0010, 4'd2, 1'b1, 4'h2, 1'b0};
        vecs[2] = '{4'b0100, 4'b0100, 4'd3, 1'b1, 4'h2, 1'b0};
        vecs[3] = '{4'b1000, 4'b1000, 4'd4, 1'b1, 4'h2, 1'b0};
        vecs[4] = '{4'b0100, 4'b0100, 4'd5, 1'b1, 4'h2, 1'b0};
        vecs[5] = '{4'b0010, 4'b0010, 4'd6, 1'b1, 4'h2, 1'b0};
        vecs[6] = '{4'b0100, 4'b0100, 4'd6, 1'b0, 4'hE, 1'b1};

        // ---- reset, then idle ----
        reset = 1'b0;
        iniciar = 1'b0;
        chaves = 4'b0000;
        step(1);
        reset = 1'b1;
        step(15);
        check("reset_estado", {1'b0, db_estado}, {1'b0, seg_tab[0]});
        check("reset_contagem", {1'b0, db_contagem}, {1'b0, seg_tab[0]});
        check("reset_pronto", {7'd0, pronto}, 8'd0);
        check("reset_acertou", {7'd0, acertou}, 8'd0);
        check("reset_errou", {7'd0, errou}, 8'd0);
        check("reset_leds", {4'd0, leds}, 8'd0);

        // ---- a play in inicial is ignored ----
        play(4'b0001, 3, 3, n_reg, n_pulse, ig);
        check("inicial_ignores_play", {1'b0, db_estado}, {1'b0, seg_tab[0]});

        // ---- start ----
        iniciar = 1'b1;
        step(5);
        iniciar = 1'b0;
        step(2);
        check("start_estado", {1'b0, db_estado}, {1'b0, seg_tab[2]});
        check("start_memoria", {1'b0, db_memoria}, {1'b0, seg_tab[1]});
        check("start_contagem", {1'b0, db_contagem}, {1'b0, seg_tab[0]});

        // ---- table-driven plays: six correct, seventh wrong ----
        for (int k = 0; k < 7; k++) begin
            play(vecs[k].chaves, 10, 10, n_reg, n_pulse, ig);
            $display("play %0d chaves=%b leds=%b estado=%b", k, vecs[k].chaves, leds, db_estado);
            check($sformatf("v%0d_registra_once", k), 8'(n_reg), 8'd1);
            check($sformatf("v%0d_one_pulse", k), 8'(n_pulse), 8'd1);
            check($sformatf("v%0d_igual", k), {7'd0, ig}, {7'd0, vecs[k].exp_igual});
            check($sformatf("v%0d_leds", k), {4'd0, leds}, {4'd0, vecs[k].exp_leds});
            check($sformatf("v%0d_contagem", k), {1'b0, db_contagem}, {1'b0, seg_tab[vecs[k].exp_cnt]});
            check($sformatf("v%0d_estado", k), {1'b0, db_estado}, {1'b0, seg_tab[vecs[k].exp_state]});
            check($sformatf("v%0d_errou", k), {7'd0, errou}, {7'd0, vecs[k].exp_errou});
        end
        check("loss_pronto", {7'd0, pronto}, 8'd1);
        check("loss_acertou", {7'd0, acertou}, 8'd0);

        // ---- restart from fim_errou, then a full winning game ----
        iniciar = 1'b1;
        step(2);
        iniciar = 1'b0;
        check("restart_estado", {1'b0, db_estado}, {1'b0, seg_tab[2]});
        check("restart_contagem", {1'b0, db_contagem}, {1'b0, seg_tab[0]});
        check("restart_leds", {4'd0, leds}, 8'd0);
        for (int k = 0; k < 16; k++) begin
            play(seq_tab[k], 4, 4, n_reg, n_pulse, ig);
            $display("win play %0d chaves=%b estado=%b", k, seq_tab[k], db_estado);
            check($sformatf("win%0d_igual", k), {7'd0, ig}, 8'd1);
        end
        check("win_estado", {1'b0, db_estado}, {1'b0, seg_tab[10]});
        check("win_acertou", {7'd0, acertou}, 8'd1);
        check("win_pronto", {7'd0, pronto}, 8'd1);
        check("win_errou", {7'd0, errou}, 8'd0);
        check("win_contagem", {1'b0, db_contagem}, {1'b0, seg_tab[15]});

        iniciar = 1'b1;
        step(2);
        iniciar = 1'b0;
        check("win_restart_estado", {1'b0, db_estado}, {1'b0, seg_tab[2]});
        check("win_restart_contagem", {1'b0, db_contagem}, {1'b0, seg_tab[0]});

        // ---- reset mid-game while in espera ----
        play(4'b0001, 4, 4, n_reg, n_pulse, ig);
        play(4'b0010, 4, 4, n_reg, n_pulse, ig);
        check("mid_contagem_before", {1'b0, db_contagem}, {1'b0, seg_tab[2]});
        #2;
        reset = 1'b0;
        #1;
        check("midreset_estado", {1'b0, db_estado}, {1'b0, seg_tab[0]});
        check("midreset_contagem", {1'b0, db_contagem}, {1'b0, seg_tab[0]});
        check("midreset_leds", {4'd0, leds}, 8'd0);
        step(1);
        reset = 1'b1;
        step(3);
        check("after_reset_estado", {1'b0, db_estado}, {1'b0, seg_tab[0]});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
